// File: rtl/spi_adc_scanner.sv
// Multi-channel SPI ADC scanner: walks the enabled channels of a pipelined ADC
// and returns one tagged result per channel, with single-scan and continuous modes.
module spi_adc_scanner #(
    parameter int NUM_CH     = 8,
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 12,
    parameter int FRAME_BITS = 16,
    parameter int CLK_DIV    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              sclk,
    output logic              cs,
    output logic              din,
    input  logic              dout,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] data_ch,
    output logic              data_valid,
    output logic              scan_done,
    output logic              busy
);

    localparam int CNT_W = $clog2(2 * CLK_DIV) + 1;
    localparam int BIT_W = $clog2(FRAME_BITS) + 1;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt;
    logic                high;
    logic [BIT_W-1:0]    bit_cnt;
    logic [NUM_CH-1:0]   mask_q, mask_nx;
    logic [ADDR_W-1:0]   cur_ch, prev_ch;
    logic                cur_last, prev_last, prev_vld, stop_q;
    logic [DATA_W-2:0]   shreg;
    logic [DATA_W-1:0]   sample_word;
    logic                half_end, gap_end, last_bit, accept;

    function automatic logic [ADDR_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
        lowest_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (m[i]) lowest_ch = ADDR_W'(i);
    endfunction

    function automatic logic [ADDR_W-1:0] highest_ch(input logic [NUM_CH-1:0] m);
        highest_ch = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (m[i]) highest_ch = ADDR_W'(i);
    endfunction

    function automatic logic [ADDR_W-1:0] next_ch(input logic [NUM_CH-1:0] m,
                                                 input logic [ADDR_W-1:0] c);
        next_ch = c;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (m[i] && i > int'(c)) next_ch = ADDR_W'(i);
    endfunction

    // Frame bit b carries the address MSB-first on bits 2..2+ADDR_W-1.
    function automatic logic frame_bit(input logic [ADDR_W-1:0] addr, input int b);
        frame_bit = 1'b0;
        for (int i = 0; i < ADDR_W; i++)
            if (b == i + 2) frame_bit = addr[ADDR_W-1-i];
    endfunction

    assign half_end    = (cnt == CNT_W'(CLK_DIV - 1));
    assign gap_end     = (cnt == CNT_W'(2 * CLK_DIV - 1));
    assign last_bit    = (bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign accept      = (state == IDLE) && start && (|ch_mask);
    assign mask_nx     = (|ch_mask) ? ch_mask : mask_q;
    assign sample_word = {shreg, dout};

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        cs       = 1'b1;
        sclk     = 1'b1;
        busy     = (state != IDLE);
        unique case (state)
            IDLE:  if (accept) state_nx = SETUP;
            SETUP: begin
                cs = 1'b0;
                if (half_end) state_nx = SHIFT;
            end
            SHIFT: begin
                cs   = 1'b0;
                sclk = high;
                if (high && half_end && last_bit) state_nx = GAP;
            end
            GAP:   if (gap_end) state_nx = stop_q ? IDLE : SETUP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            high       <= 1'b0;
            bit_cnt    <= '0;
            din        <= 1'b0;
            shreg      <= '0;
            data_out   <= '0;
            data_ch    <= '0;
            data_valid <= 1'b0;
            scan_done  <= 1'b0;
            mask_q     <= '0;
            cur_ch     <= '0;
            prev_ch    <= '0;
            cur_last   <= 1'b0;
            prev_last  <= 1'b0;
            prev_vld   <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            scan_done  <= 1'b0;
            cnt        <= cnt + 1'b1;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        mask_q   <= ch_mask;
                        cur_ch   <= lowest_ch(ch_mask);
                        cur_last <= (lowest_ch(ch_mask) == highest_ch(ch_mask));
                        prev_vld <= 1'b0;
                        stop_q   <= 1'b0;
                    end
                end
                SETUP: if (half_end) begin
                    cnt     <= '0;
                    high    <= 1'b0;
                    bit_cnt <= '0;
                    din     <= frame_bit(cur_ch, 0);
                end
                SHIFT: if (half_end) begin
                    cnt <= '0;
                    if (!high) begin
                        high  <= 1'b1;
                        shreg <= sample_word[DATA_W-2:0];
                        // Last sample: retire the previous frame's channel, pick the next address.
                        if (last_bit) begin
                            if (prev_vld) begin
                                data_out <= sample_word;
                                data_ch  <= prev_ch;
                            end
                            data_valid <= prev_vld;
                            scan_done  <= prev_vld && prev_last;
                            stop_q     <= prev_vld && prev_last && !cont;
                            prev_ch    <= cur_ch;
                            prev_last  <= cur_last;
                            prev_vld   <= 1'b1;
                            if (cur_last) begin
                                mask_q   <= mask_nx;
                                cur_ch   <= lowest_ch(mask_nx);
                                cur_last <= (lowest_ch(mask_nx) == highest_ch(mask_nx));
                            end else begin
                                cur_ch   <= next_ch(mask_q, cur_ch);
                                cur_last <= (next_ch(mask_q, cur_ch) == highest_ch(mask_q));
                            end
                        end
                    end else if (!last_bit) begin
                        high    <= 1'b0;
                        bit_cnt <= bit_cnt + 1'b1;
                        din     <= frame_bit(cur_ch, int'(bit_cnt) + 1);
                    end
                end
                GAP: if (gap_end) cnt <= '0;
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_adc_scanner.sv
// Directed bench for spi_adc_scanner with a behavioural pipelined ADC that
// returns the previous frame's channel value and logs frame shape and results.
module tb_spi_adc_scanner;

    localparam int NUM_CH = 8, ADDR_W = 3, DATA_W = 12, FRAME_BITS = 16, CLK_DIV = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              cont = 1'b0;
    logic [NUM_CH-1:0] ch_mask = '0;
    logic              sclk, cs, din;
    logic              dout = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic [ADDR_W-1:0] data_ch;
    logic              data_valid, scan_done, busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spi_adc_scanner #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .FRAME_BITS(FRAME_BITS), .CLK_DIV(CLK_DIV)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .ch_mask(ch_mask),
        .sclk(sclk), .cs(cs), .din(din), .dout(dout),
        .data_out(data_out), .data_ch(data_ch), .data_valid(data_valid),
        .scan_done(scan_done), .busy(busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ADC model state and logs
    logic [11:0] adc_val [8] = '{12'h5A3, 12'h1B1, 12'hC3C, 12'h3D3,
                                 12'h444, 12'h555, 12'h666, 12'hFFF};
    logic [2:0]  adc_last = '0;
    logic [2:0]  addr_sh  = '0;
    logic [15:0] adc_frame = '0;
    logic        din_prev = 1'b0;
    int  nfall = 0, nrise = 0, din_viol = 0, per_err = 0;
    time last_fall = 0, cs_fall_t = 0, cs_rise_t = 0, busy_fall_t = 0;

    int         nframes = 0;
    logic [2:0] f_addr  [64];
    int         f_falls [64];
    int         f_low   [64];
    int         f_viol  [64];
    int         f_per   [64];

    int          nres = 0, n_sd = 0, sd_orphan = 0;
    logic [2:0]  r_ch   [64];
    logic [11:0] r_data [64];
    logic        r_sd   [64];

    initial forever begin
        @(negedge cs);
        adc_frame = {4'h0, adc_val[adc_last]};
        nfall = 0; nrise = 0; addr_sh = '0; din_viol = 0; per_err = 0;
        cs_fall_t = $time;
    end

    initial forever begin
        @(negedge sclk);
        if (cs == 1'b0) begin
            if (nfall > 0 && ($time - last_fall) != 40) per_err++;
            last_fall = $time;
            if (nfall < 16) dout = adc_frame[15 - nfall];
            nfall++;
        end
    end

    initial forever begin
        @(negedge clk);
        din_prev = din;
    end

    initial forever begin
        @(posedge sclk);
        if (cs == 1'b0) begin
            if (din !== din_prev) din_viol++;
            if (nrise >= 2 && nrise < 2 + ADDR_W) addr_sh = {addr_sh[1:0], din};
            nrise++;
        end
    end

    initial forever begin
        @(posedge cs);
        cs_rise_t = $time;
        if (nrise == 16 && nframes < 64) begin
            adc_last         = addr_sh;
            f_addr[nframes]  = addr_sh;
            f_falls[nframes] = nfall;
            f_low[nframes]   = int'($time - cs_fall_t);
            f_viol[nframes]  = din_viol;
            f_per[nframes]   = per_err;
            nframes++;
        end
    end

    initial forever begin
        @(negedge busy);
        busy_fall_t = $time;
    end

    initial forever begin
        @(negedge clk);
        if (data_valid === 1'b1 && nres < 64) begin
            r_ch[nres]   = data_ch;
            r_data[nres] = data_out;
            r_sd[nres]   = scan_done;
            nres++;
        end else if (scan_done === 1'b1) begin
            sd_orphan++;
        end
        if (scan_done === 1'b1) n_sd++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic check_frame(input string tag, input int idx, input logic [2:0] addr);
        check_eq($sformatf("%s_f%0d_addr", tag, idx), f_addr[idx], addr);
        check_eq($sformatf("%s_f%0d_falls", tag, idx), f_falls[idx], 16);
        check_eq($sformatf("%s_f%0d_cslow", tag, idx), f_low[idx], 660);
        check_eq($sformatf("%s_f%0d_dinstable", tag, idx), f_viol[idx], 0);
        check_eq($sformatf("%s_f%0d_period", tag, idx), f_per[idx], 0);
    endtask

    task automatic check_res(input string tag, input int idx, input logic [2:0] ch,
                             input logic [11:0] val, input logic sd);
        check_eq($sformatf("%s_r%0d_ch", tag, idx), r_ch[idx], ch);
        check_eq($sformatf("%s_r%0d_data", tag, idx), r_data[idx], val);
        check_eq($sformatf("%s_r%0d_sd", tag, idx), r_sd[idx], sd);
    endtask

    initial begin
        int fb, rb, sb, k;

        // Reset with a simultaneous start request
        rst = 1'b0; start = 1'b1; ch_mask = 8'h05;
        tick(4);
        check_eq("rst_cs", cs, 1'b1);
        check_eq("rst_sclk", sclk, 1'b1);
        check_eq("rst_din", din, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_valid", data_valid, 1'b0);
        check_eq("rst_done", scan_done, 1'b0);
        check_eq("rst_data", data_out, 12'h000);
        check_eq("rst_ch", data_ch, 3'd0);
        start = 1'b0; rst = 1'b1;
        tick(20);
        check_eq("post_rst_busy", busy, 1'b0);
        check_eq("post_rst_frames", nframes, 0);

        // Single scan over ch0 and ch2, with an ignored start while busy
        fb = nframes; rb = nres; sb = n_sd;
        ch_mask = 8'h05; cont = 1'b0;
        pulse_start();
        tick(30);
        pulse_start();
        wait_idle("scan05", 2000);
        tick(10);
        check_eq("scan05_frames", nframes - fb, 3);
        check_frame("scan05", fb + 0, 3'd0);
        check_frame("scan05", fb + 1, 3'd2);
        check_frame("scan05", fb + 2, 3'd0);
        check_eq("scan05_nres", nres - rb, 2);
        check_res("scan05", rb + 0, 3'd0, 12'h5A3, 1'b0);
        check_res("scan05", rb + 1, 3'd2, 12'hC3C, 1'b1);
        check_eq("scan05_nsd", n_sd - sb, 1);
        check_eq("scan05_busy_fall", int'(busy_fall_t - cs_rise_t), 40);
        check_eq("scan05_hold_data", data_out, 12'hC3C);
        check_eq("scan05_hold_ch", data_ch, 3'd2);

        // Start with an empty mask is ignored
        fb = nframes;
        ch_mask = 8'h00;
        pulse_start();
        tick(20);
        check_eq("mask0_busy", busy, 1'b0);
        check_eq("mask0_frames", nframes - fb, 0);

        // Continuous single-channel scanning for three scans
        fb = nframes; rb = nres; sb = n_sd;
        ch_mask = 8'h80; cont = 1'b1;
        pulse_start();
        k = 0;
        while ((n_sd - sb) < 2 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check_eq("cont_second_done", n_sd - sb, 2);
        cont = 1'b0;
        wait_idle("cont80", 3000);
        tick(10);
        check_eq("cont80_frames", nframes - fb, 4);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("cont80_f%0d_addr", i), f_addr[fb + i], 3'd7);
        check_eq("cont80_nres", nres - rb, 3);
        for (int i = 0; i < 3; i++)
            check_res("cont80", rb + i, 3'd7, 12'hFFF, 1'b1);
        check_eq("cont80_nsd", n_sd - sb, 3);

        // Reset in the middle of the second frame, then restart
        fb = nframes; rb = nres;
        ch_mask = 8'h05; cont = 1'b0;
        pulse_start();
        k = 0;
        while (!(nframes == fb + 1 && nrise >= 9) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_eq("midrst_reached_bit9", (nframes == fb + 1 && nrise >= 9), 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_cs", cs, 1'b1);
        check_eq("midrst_sclk", sclk, 1'b1);
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_valid", data_valid, 1'b0);
        tick(2);
        rst = 1'b1;
        tick(5);
        check_eq("midrst_nres", nres - rb, 0);
        check_eq("midrst_frames", nframes - fb, 1);
        fb = nframes; rb = nres;
        pulse_start();
        wait_idle("restart", 2000);
        tick(10);
        check_eq("restart_frames", nframes - fb, 3);
        check_eq("restart_nres", nres - rb, 2);
        check_res("restart", rb + 0, 3'd0, 12'h5A3, 1'b0);
        check_res("restart", rb + 1, 3'd2, 12'hC3C, 1'b1);

        // Mask change mid-scan takes effect at the wrap
        fb = nframes; rb = nres; sb = n_sd;
        ch_mask = 8'h03; cont = 1'b1;
        pulse_start();
        tick(3);
        ch_mask = 8'h0C;
        k = 0;
        while ((n_sd - sb) < 1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check_eq("remask_first_done", n_sd - sb, 1);
        cont = 1'b0;
        wait_idle("remask", 3000);
        tick(10);
        check_eq("remask_frames", nframes - fb, 5);
        check_eq("remask_f0", f_addr[fb + 0], 3'd0);
        check_eq("remask_f1", f_addr[fb + 1], 3'd1);
        check_eq("remask_f2", f_addr[fb + 2], 3'd2);
        check_eq("remask_f3", f_addr[fb + 3], 3'd3);
        check_eq("remask_f4", f_addr[fb + 4], 3'd2);
        check_eq("remask_nres", nres - rb, 4);
        check_res("remask", rb + 0, 3'd0, 12'h5A3, 1'b0);
        check_res("remask", rb + 1, 3'd1, 12'h1B1, 1'b1);
        check_res("remask", rb + 2, 3'd2, 12'hC3C, 1'b0);
        check_res("remask", rb + 3, 3'd3, 12'h3D3, 1'b1);
        check_eq("remask_nsd", n_sd - sb, 2);
        check_eq("orphan_scan_done", sd_orphan, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_adc_scanner.md
SPI_ADC_SCANNER -- requirements
Module: spi_adc_scanner

Interface
REQ-001 Parameter NUM_CH, default 8, number of ADC input channels (2..8).
REQ-002 Parameter ADDR_W, default 3, channel address bits in the frame; 2**ADDR_W >= NUM_CH.
REQ-003 Parameter DATA_W, default 12, conversion result width.
REQ-004 Parameter FRAME_BITS, default 16, SCLK cycles per frame; FRAME_BITS >= DATA_W+2+ADDR_W-ADDR_W... fixed rule: FRAME_BITS >= DATA_W+4 and >= 2+ADDR_W.
REQ-005 Parameter CLK_DIV, default 4, clk cycles per SCLK half-period (>=1).
REQ-006 clk  in  1  system clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous active-low reset.
REQ-008 start  in  1  single-cycle scan request.
REQ-009 cont  in  1  continuous-scan mode enable.
REQ-010 ch_mask  in  NUM_CH  enabled channels, bit i = channel i.
REQ-011 sclk  out  1  SPI clock, idle high.
REQ-012 cs  out  1  chip select, active low, idle high.
REQ-013 din  out  1  serial data to ADC (address).
REQ-014 dout  in  1  serial data from ADC.
REQ-015 data_out  out  DATA_W  last converted result.
REQ-016 data_ch  out  ADDR_W  channel of data_out.
REQ-017 data_valid  out  1  one-clk result strobe.
REQ-018 scan_done  out  1  one-clk strobe after last enabled channel's result.
REQ-019 busy  out  1  high from accepted start until return to IDLE.

Function
REQ-020 FSM states IDLE, SETUP, SHIFT, GAP; IDLE->SETUP on start=1 with ch_mask!=0; start with ch_mask=0 or while busy ignored.
REQ-021 ch_mask latched on accepted start and at each scan wrap; live changes otherwise ignored.
REQ-022 SETUP: cs low, sclk high for CLK_DIV clks, then SHIFT.
REQ-023 SHIFT: FRAME_BITS SCLK periods, each CLK_DIV clks low then CLK_DIV clks high; din changes only on sclk falling edge; dout sampled on sclk rising edge, MSB first.
REQ-024 din drives address MSB-first on frame bits 2..2+ADDR_W-1 (bit 0 = first SCLK); all other bits 0.
REQ-025 Result = last DATA_W dout samples of the frame; earlier samples discarded.
REQ-026 ADC pipeline: result in frame k belongs to channel addressed in frame k-1; block tracks this internally.
REQ-027 First frame after accepted start is a priming frame: no data_valid.
REQ-028 Channel order: ascending over latched mask, lowest set bit first, wrap to lowest after highest.
REQ-029 data_valid, data_out, data_ch update one clk after the final rising-edge sample of a frame; data_out/data_ch hold until next update.
REQ-030 GAP: cs high, sclk high for 2*CLK_DIV clks, then SETUP or IDLE.
REQ-031 cont=0 (sampled at scan_done): one scan = N+1 frames for N enabled channels, then IDLE; final frame addresses lowest enabled channel, data ignored beyond completing last result.
REQ-032 cont=1 at scan_done: next frame follows without priming; scanning continues until scan_done sees cont=0.
REQ-033 scan_done asserts same clk as data_valid for highest enabled channel.
REQ-034 Single enabled channel: each frame after priming yields one result and one scan_done.
REQ-035 busy falls on the clk IDLE is entered; start accepted same clk busy is low.

Reset
REQ-036 rst=0 at any clk edge, including mid-frame: next state IDLE; cs=1, sclk=1, din=0, data_valid=0, scan_done=0, busy=0, data_out=0, data_ch=0; partial frame discarded.
REQ-037 rst=0 overrides simultaneous start; no frame started until start after rst=1.

Verification
REQ-038 NUM_CH=8, CLK_DIV=2, mask=8'h05, cont=0, ADC model returns 12'h5A3 (ch0), 12'hC3C (ch2) -> 3 frames, din address 000,010,000; data_valid (0,5A3) then (2,C3C) with scan_done; busy low after frame 3 GAP.
REQ-039 Frame timing check, CLK_DIV=2: 16 sclk falling edges per frame, sclk period 4 clks, cs low 66 clks per frame, din stable across each rising edge.
REQ-040 mask=8'h80, cont=1 for 3 scans then cont=0, ADC returns 12'hFFF -> 4 frames, 3 results (7,FFF), 3 scan_done pulses, return to IDLE.
REQ-041 rst driven low at frame bit 9 -> cs=1, sclk=1, busy=0 next clk; no data_valid; restart yields correct first result after priming.
REQ-042 start with mask=0, and start pulse while busy -> no state change, no extra frames.
REQ-043 Mask changed mid-scan from 8'h03 to 8'h0C with cont=1 -> current scan completes for ch0,ch1; next scan covers ch2,ch3.
